tl_data_downsizer_buf: RTL and testbench

Buffered, fully registered TileLink data-width downsizer. It narrows A/C beats from HostDataWidth to DeviceDataWidth for any power-of-two ratio, and reassembles D subbeats into host beats through a response queue of configurable depth. Unlike the unbuffered downsizer, it captures each host beat into its own holding register, so no input regslice is needed. It also derives subbeat counts from opcode and size itself, so dataless messages always cost one beat. It sits between a wide host-side crossbar port and a narrow device, such as a 32-bit peripheral bus behind a 64/128-bit core port.

---
 rtl/tl_data_downsizer_buf.sv | 256 +++++++++++++++++++++++++
 tb/tb_tl_data_downsizer_buf.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tl_data_downsizer_buf.sv
// Buffered TileLink data downsizer: splits wide A/C beats into narrow subbeats and
// reassembles narrow D subbeats into wide host beats through a small response queue.
module tl_dds_split #(
  parameter int MW = 8,
  parameter int LW = 8,
  parameter int R  = 2,
  parameter int SB = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MW-1:0]   in_meta,
  input  logic [R*LW-1:0] in_pay,
  input  logic [SB-1:0]   in_nmask,
  input  logic [SB-1:0]   in_idx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [MW-1:0]   out_meta,
  output logic [LW-1:0]   out_slice
);
  logic            hold_valid_reg;
  logic [MW-1:0]   meta_reg;
  logic [R*LW-1:0] pay_reg;
  logic [SB-1:0]   nmask_reg, start_reg, cnt_reg;
  logic [LW-1:0]   slices [R];
  logic            last, out_fire;

  for (genvar gi = 0; gi < R; gi++) begin : g_slice
    assign slices[gi] = pay_reg[gi*LW +: LW];
  end

  assign last      = (cnt_reg == nmask_reg);
  assign out_valid = hold_valid_reg;
  assign out_fire  = hold_valid_reg && out_ready;
  assign in_ready  = !hold_valid_reg || (out_ready && last);
  assign out_meta  = meta_reg;
  // Burst slices start at the size-aligned index and count upward from there.
  assign out_slice = slices[start_reg | cnt_reg];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid_reg <= 1'b0;
      meta_reg       <= '0;
      pay_reg        <= '0;
      nmask_reg      <= '0;
      start_reg      <= '0;
      cnt_reg        <= '0;
    end else begin
      if (out_fire) cnt_reg <= last ? '0 : cnt_reg + 1'b1;
      if (in_valid && in_ready) begin
        hold_valid_reg <= 1'b1;
        meta_reg       <= in_meta;
        pay_reg        <= in_pay;
        nmask_reg      <= in_nmask;
        start_reg      <= in_idx & ~in_nmask;
      end else if (out_fire && last) begin
        hold_valid_reg <= 1'b0;
      end
    end
  end
endmodule

module tl_data_downsizer_buf #(
  parameter int HostDataWidth   = 64,
  parameter int DeviceDataWidth = 32,
  parameter int AddrWidth       = 56,
  parameter int SourceWidth     = 1,
  parameter int SinkWidth       = 1,
  parameter int MaxSize         = 6,
  parameter int DQueueDepth     = 2,
  localparam int SzW   = $clog2(MaxSize + 1),
  localparam int AHdrW = 6 + SzW + SourceWidth + AddrWidth,
  localparam int HAW   = AHdrW + HostDataWidth / 8 + HostDataWidth + 1,
  localparam int DAW   = AHdrW + DeviceDataWidth / 8 + DeviceDataWidth + 1,
  localparam int BW    = AHdrW,
  localparam int HCW   = AHdrW + HostDataWidth + 1,
  localparam int DCW   = AHdrW + DeviceDataWidth + 1,
  localparam int DHdrW = 6 + SzW + SourceWidth + SinkWidth,
  localparam int HDW   = DHdrW + 1 + HostDataWidth + 1,
  localparam int DDW   = DHdrW + 1 + DeviceDataWidth + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 host_a_valid,
  output logic                 host_a_ready,
  input  logic [HAW-1:0]       host_a,
  output logic                 host_b_valid,
  input  logic                 host_b_ready,
  output logic [BW-1:0]        host_b,
  input  logic                 host_c_valid,
  output logic                 host_c_ready,
  input  logic [HCW-1:0]       host_c,
  output logic                 host_d_valid,
  input  logic                 host_d_ready,
  output logic [HDW-1:0]       host_d,
  input  logic                 host_e_valid,
  output logic                 host_e_ready,
  input  logic [SinkWidth-1:0] host_e,
  output logic                 device_a_valid,
  input  logic                 device_a_ready,
  output logic [DAW-1:0]       device_a,
  input  logic                 device_b_valid,
  output logic                 device_b_ready,
  input  logic [BW-1:0]        device_b,
  output logic                 device_c_valid,
  input  logic                 device_c_ready,
  output logic [DCW-1:0]       device_c,
  input  logic                 device_d_valid,
  output logic                 device_d_ready,
  input  logic [DDW-1:0]       device_d,
  output logic                 device_e_valid,
  input  logic                 device_e_ready,
  output logic [SinkWidth-1:0] device_e
);
  localparam int R   = HostDataWidth / DeviceDataWidth;
  localparam int HNB = $clog2(HostDataWidth / 8);
  localparam int DNB = $clog2(DeviceDataWidth / 8);
  localparam int SB  = HNB - DNB;
  localparam int DMW = DeviceDataWidth / 8;
  localparam int ALW = DMW + DeviceDataWidth;
  localparam int PW  = (DQueueDepth > 1) ? $clog2(DQueueDepth) : 1;
  localparam int CW  = $clog2(DQueueDepth + 1);

  // Subbeats-minus-one as a mask: dataless or narrow messages take a single beat.
  function automatic logic [SB-1:0] nmask_f(input logic has_data, input logic [SzW-1:0] size);
    nmask_f = '0;
    if (has_data && int'(size) > DNB) begin
      if (int'(size) >= HNB) nmask_f = '1;
      else nmask_f = SB'((1 << (int'(size) - DNB)) - 1);
    end
  endfunction

  logic [AHdrW-1:0] a_hdr, c_hdr, a_dev_meta_hdr, c_dev_meta_hdr;
  logic [AHdrW:0]   a_dev_meta, c_dev_meta;
  logic [R*ALW-1:0] a_pay;
  logic [ALW-1:0]   a_dev_slice;
  logic [DeviceDataWidth-1:0] c_dev_slice;
  logic [2:0]       c_op;

  assign a_hdr = host_a[HAW-1 -: AHdrW];
  assign c_hdr = host_c[HCW-1 -: AHdrW];
  assign c_op  = c_hdr[AHdrW-1 -: 3];

  // Interleave mask and data per lane so one slice select serves both.
  for (genvar gi = 0; gi < R; gi++) begin : g_a_lane
    assign a_pay[gi*ALW +: ALW] = {host_a[1 + HostDataWidth + gi*DMW +: DMW],
                                   host_a[1 + gi*DeviceDataWidth +: DeviceDataWidth]};
  end

  tl_dds_split #(.MW(AHdrW + 1), .LW(ALW), .R(R), .SB(SB)) u_split_a (
    .clk_i, .rst_i,
    .in_valid (host_a_valid),
    .in_ready (host_a_ready),
    .in_meta  ({a_hdr, host_a[0]}),
    .in_pay   (a_pay),
    .in_nmask (nmask_f(!a_hdr[AHdrW-1], a_hdr[SourceWidth+AddrWidth +: SzW])),
    .in_idx   (a_hdr[HNB-1:DNB]),
    .out_valid(device_a_valid),
    .out_ready(device_a_ready),
    .out_meta (a_dev_meta),
    .out_slice(a_dev_slice)
  );
  assign a_dev_meta_hdr = a_dev_meta[AHdrW:1];
  assign device_a = {a_dev_meta_hdr, a_dev_slice, a_dev_meta[0]};

  tl_dds_split #(.MW(AHdrW + 1), .LW(DeviceDataWidth), .R(R), .SB(SB)) u_split_c (
    .clk_i, .rst_i,
    .in_valid (host_c_valid),
    .in_ready (host_c_ready),
    .in_meta  ({c_hdr, host_c[0]}),
    .in_pay   (host_c[HostDataWidth:1]),
    .in_nmask (nmask_f(!(c_op == 3'd4 || c_op == 3'd6), c_hdr[SourceWidth+AddrWidth +: SzW])),
    .in_idx   (c_hdr[HNB-1:DNB]),
    .out_valid(device_c_valid),
    .out_ready(device_c_ready),
    .out_meta (c_dev_meta),
    .out_slice(c_dev_slice)
  );
  assign c_dev_meta_hdr = c_dev_meta[AHdrW:1];
  assign device_c = {c_dev_meta_hdr, c_dev_slice, c_dev_meta[0]};

  assign host_b_valid   = device_b_valid;
  assign host_b         = device_b;
  assign device_b_ready = host_b_ready;
  assign device_e_valid = host_e_valid;
  assign device_e       = host_e;
  assign host_e_ready   = device_e_ready;

  logic [DHdrW-1:0]           d_hdr;
  logic [2:0]                 d_op;
  logic [DeviceDataWidth-1:0] d_data;
  logic [SB-1:0]              d_nmask, d_cnt_reg;
  logic [HostDataWidth-1:0]   acc_data_reg, asm_data;
  logic                       corrupt_acc_reg, denied_acc_reg;
  logic                       d_last, d_fire, d_push, d_pop, fifo_full;
  logic [HDW-1:0]             fifo_in;
  logic [HDW-1:0]             fifo_mem [DQueueDepth];
  logic [PW-1:0]              wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]              count_reg;

  assign d_hdr   = device_d[DDW-1 -: DHdrW];
  assign d_op    = d_hdr[DHdrW-1 -: 3];
  assign d_data  = device_d[DeviceDataWidth:1];
  assign d_nmask = nmask_f(d_op == 3'd1 || d_op == 3'd5, d_hdr[SourceWidth+SinkWidth +: SzW]);
  assign d_last  = (d_cnt_reg == d_nmask);

  // Narrow responses are replicated across every host lane congruent to the subbeat index.
  for (genvar gi = 0; gi < R; gi++) begin : g_d_lane
    assign asm_data[gi*DeviceDataWidth +: DeviceDataWidth] =
      ((SB'(gi) & d_nmask) == d_cnt_reg) ? d_data : acc_data_reg[gi*DeviceDataWidth +: DeviceDataWidth];
  end

  assign fifo_full      = (count_reg == CW'(DQueueDepth));
  assign device_d_ready = !d_last || !fifo_full;
  assign d_fire         = device_d_valid && device_d_ready;
  assign d_push         = d_fire && d_last;
  assign d_pop          = host_d_valid && host_d_ready;
  assign fifo_in        = {d_hdr, device_d[DeviceDataWidth+1] | denied_acc_reg, asm_data,
                           device_d[0] | corrupt_acc_reg};
  assign host_d_valid   = (count_reg != '0);
  assign host_d         = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_cnt_reg       <= '0;
      acc_data_reg    <= '0;
      corrupt_acc_reg <= 1'b0;
      denied_acc_reg  <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      if (d_fire) begin
        acc_data_reg <= asm_data;
        if (d_last) begin
          d_cnt_reg       <= '0;
          corrupt_acc_reg <= 1'b0;
          denied_acc_reg  <= 1'b0;
        end else begin
          d_cnt_reg       <= d_cnt_reg + 1'b1;
          corrupt_acc_reg <= corrupt_acc_reg | device_d[0];
          denied_acc_reg  <= denied_acc_reg | device_d[DeviceDataWidth+1];
        end
      end
      if (d_push) wr_ptr_reg <= (wr_ptr_reg == PW'(DQueueDepth - 1)) ? '0 : wr_ptr_reg + 1'b1;
      if (d_pop)  rd_ptr_reg <= (rd_ptr_reg == PW'(DQueueDepth - 1)) ? '0 : rd_ptr_reg + 1'b1;
      if (d_push && !d_pop)      count_reg <= count_reg + 1'b1;
      else if (!d_push && d_pop) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (d_push) fifo_mem[wr_ptr_reg] <= fifo_in;
  end
endmodule

// File: tb/tb_tl_data_downsizer_buf.sv
// Directed bench for tl_data_downsizer_buf at 64->32 bits with a two-entry D queue.
module tb_tl_data_downsizer_buf;
  logic         clk, rst_i;
  logic         host_a_valid, host_a_ready;
  logic [138:0] host_a;
  logic         host_b_valid, host_b_ready;
  logic [65:0]  host_b;
  logic         host_c_valid, host_c_ready;
  logic [130:0] host_c;
  logic         host_d_valid, host_d_ready;
  logic [76:0]  host_d;
  logic         host_e_valid, host_e_ready;
  logic [0:0]   host_e;
  logic         device_a_valid, device_a_ready;
  logic [102:0] device_a;
  logic         device_b_valid, device_b_ready;
  logic [65:0]  device_b;
  logic         device_c_valid, device_c_ready;
  logic [98:0]  device_c;
  logic         device_d_valid, device_d_ready;
  logic [44:0]  device_d;
  logic         device_e_valid, device_e_ready;
  logic [0:0]   device_e;

  int n_tests = 0;
  int n_fail  = 0;

  tl_data_downsizer_buf dut (
    .clk_i(clk), .rst_i(rst_i),
    .host_a_valid(host_a_valid), .host_a_ready(host_a_ready), .host_a(host_a),
    .host_b_valid(host_b_valid), .host_b_ready(host_b_ready), .host_b(host_b),
    .host_c_valid(host_c_valid), .host_c_ready(host_c_ready), .host_c(host_c),
    .host_d_valid(host_d_valid), .host_d_ready(host_d_ready), .host_d(host_d),
    .host_e_valid(host_e_valid), .host_e_ready(host_e_ready), .host_e(host_e),
    .device_a_valid(device_a_valid), .device_a_ready(device_a_ready), .device_a(device_a),
    .device_b_valid(device_b_valid), .device_b_ready(device_b_ready), .device_b(device_b),
    .device_c_valid(device_c_valid), .device_c_ready(device_c_ready), .device_c(device_c),
    .device_d_valid(device_d_valid), .device_d_ready(device_d_ready), .device_d(device_d),
    .device_e_valid(device_e_valid), .device_e_ready(device_e_ready), .device_e(device_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [138:0] mk_ha(logic [2:0] op, logic [2:0] sz, logic [55:0] addr,
                                         logic [7:0] mask, logic [63:0] data);
    return {op, 3'd0, sz, 1'b0, addr, mask, data, 1'b0};
  endfunction
  function automatic logic [102:0] mk_da(logic [2:0] op, logic [2:0] sz, logic [55:0] addr,
                                         logic [3:0] mask, logic [31:0] data);
    return {op, 3'd0, sz, 1'b0, addr, mask, data, 1'b0};
  endfunction
  function automatic logic [130:0] mk_hc(logic [2:0] op, logic [2:0] sz, logic [55:0] addr, logic [63:0] data);
    return {op, 3'd0, sz, 1'b0, addr, data, 1'b0};
  endfunction
  function automatic logic [98:0] mk_dc(logic [2:0] op, logic [2:0] sz, logic [55:0] addr, logic [31:0] data);
    return {op, 3'd0, sz, 1'b0, addr, data, 1'b0};
  endfunction
  function automatic logic [44:0] mk_dd(logic [2:0] op, logic [2:0] sz, logic [31:0] data, logic corrupt);
    return {op, 3'd0, sz, 1'b0, 1'b0, 1'b0, data, corrupt};
  endfunction
  function automatic logic [76:0] mk_hd(logic [2:0] op, logic [2:0] sz, logic [63:0] data, logic corrupt);
    return {op, 3'd0, sz, 1'b0, 1'b0, 1'b0, data, corrupt};
  endfunction
  function automatic logic [31:0] dv(int m, int s);
    return 32'hB000_0000 + 32'(m * 16 + s);
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    host_a_valid = 0; host_a = '0; host_b_ready = 1; host_c_valid = 0; host_c = '0;
    host_d_ready = 1; host_e_valid = 0; host_e = '0;
    device_a_ready = 1; device_b_valid = 0; device_b = '0; device_c_ready = 1;
    device_d_valid = 0; device_d = '0; device_e_ready = 1;
    tick(); tick();

    // Reset state and B/E passthrough
    chk1("rst_host_a_ready", host_a_ready, 1'b1);
    chk1("rst_host_c_ready", host_c_ready, 1'b1);
    chk1("rst_device_a_valid", device_a_valid, 1'b0);
    chk1("rst_device_c_valid", device_c_valid, 1'b0);
    chk1("rst_host_d_valid", host_d_valid, 1'b0);
    chk1("rst_device_d_ready", device_d_ready, 1'b1);
    device_b_valid = 1; device_b = {3'd6, 3'd1, 3'd6, 1'b1, 56'h1234};
    host_e_valid = 1; host_e = 1'b1;
    #1;
    chk("b_pass", 160'({host_b_valid, host_b}), 160'({1'b1, 3'd6, 3'd1, 3'd6, 1'b1, 56'h1234}));
    chk("e_pass", 160'({device_e_valid, device_e}), 160'(2'b11));
    rst_i = 0; device_b_valid = 0; host_e_valid = 0; host_e = '0;
    tick();

    // 64->32 PutFullData size 3 with a one-cycle device stall
    host_a = mk_ha(3'd0, 3'd3, 56'h100, 8'hFF, 64'h1122334455667788);
    host_a_valid = 1; device_a_ready = 0;
    #1 chk1("t1_ready_idle", host_a_ready, 1'b1);
    tick(); host_a_valid = 0; #1;
    chk("t1_sb0", 160'({device_a_valid, device_a}), 160'({1'b1, mk_da(3'd0, 3'd3, 56'h100, 4'hF, 32'h55667788)}));
    chk1("t1_ready_low", host_a_ready, 1'b0);
    tick();
    chk("t1_sb0_stall", 160'({device_a_valid, device_a}), 160'({1'b1, mk_da(3'd0, 3'd3, 56'h100, 4'hF, 32'h55667788)}));
    device_a_ready = 1; #1;
    chk1("t1_ready_low2", host_a_ready, 1'b0);
    tick(); #1;
    chk("t1_sb1", 160'({device_a_valid, device_a}), 160'({1'b1, mk_da(3'd0, 3'd3, 56'h100, 4'hF, 32'h11223344)}));
    chk1("t1_ready_last", host_a_ready, 1'b1);
    tick(); #1 chk1("t1_done", device_a_valid, 1'b0);

    // Narrow Put at upper lane, then back-to-back Get size 6
    host_a = mk_ha(3'd0, 3'd2, 56'h104, 8'hF0, 64'h1122334455667788); host_a_valid = 1;
    tick(); host_a = mk_ha(3'd4, 3'd6, 56'h40, 8'hFF, 64'h0); #1;
    chk("t2_put", 160'({device_a_valid, device_a}), 160'({1'b1, mk_da(3'd0, 3'd2, 56'h104, 4'hF, 32'h11223344)}));
    chk1("t2_ready_b2b", host_a_ready, 1'b1);
    tick(); host_a_valid = 0; #1;
    chk("t2_get", 160'({device_a_valid, device_a}), 160'({1'b1, mk_da(3'd4, 3'd6, 56'h40, 4'hF, 32'h0)}));
    tick(); #1 chk1("t2_get_one", device_a_valid, 1'b0);

    // C channel: ReleaseData size 3, then dataless Release size 6
    host_c = mk_hc(3'd7, 3'd3, 56'h8, 64'hAAAABBBBCCCCDDDD); host_c_valid = 1;
    tick(); host_c = mk_hc(3'd6, 3'd6, 56'h40, 64'h0); #1;
    chk("c_sb0", 160'({device_c_valid, device_c}), 160'({1'b1, mk_dc(3'd7, 3'd3, 56'h8, 32'hCCCCDDDD)}));
    chk1("c_ready_low", host_c_ready, 1'b0);
    tick(); #1;
    chk("c_sb1", 160'({device_c_valid, device_c}), 160'({1'b1, mk_dc(3'd7, 3'd3, 56'h8, 32'hAAAABBBB)}));
    tick(); host_c_valid = 0; #1;
    chk("c_release", 160'({device_c_valid, device_c}), 160'({1'b1, mk_dc(3'd6, 3'd6, 56'h40, 32'h0)}));
    tick(); #1 chk1("c_release_one", device_c_valid, 1'b0);

    // AccessAckData size 2 replicated across the host beat
    device_d = mk_dd(3'd1, 3'd2, 32'hDEADBEEF, 1'b0); device_d_valid = 1; host_d_ready = 1;
    #1 chk1("t3_dready", device_d_ready, 1'b1);
    chk1("t3_no_early", host_d_valid, 1'b0);
    tick(); device_d_valid = 0; #1;
    chk("t3_beat", 160'({host_d_valid, host_d}), 160'({1'b1, mk_hd(3'd1, 3'd2, 64'hDEADBEEFDEADBEEF, 1'b0)}));
    tick(); #1 chk1("t3_empty", host_d_valid, 1'b0);

    // GrantData size 6: 16 subbeats, corrupt only on subbeat 5
    for (int k = 0; k < 16; k++) begin
      device_d = mk_dd(3'd5, 3'd6, 32'hA000_0000 + k, k == 5); device_d_valid = 1;
      tick();
      if (k % 2 == 1) begin
        #1 chk($sformatf("t4_beat%0d", k / 2), 160'({host_d_valid, host_d}),
               160'({1'b1, mk_hd(3'd5, 3'd6, {32'hA000_0000 + k, 32'hA000_0000 + k - 1}, k == 5)}));
      end
    end
    device_d_valid = 0;
    tick(); #1 chk1("t4_empty", host_d_valid, 1'b0);

    // Queue full: third message's last subbeat stalls until a pop
    host_d_ready = 0;
    for (int i = 0; i < 5; i++) begin
      device_d = mk_dd(3'd1, 3'd3, dv(i / 2, i % 2), 1'b0); device_d_valid = 1;
      #1 chk1($sformatf("t5_acc%0d", i), device_d_ready, 1'b1);
      tick();
    end
    device_d = mk_dd(3'd1, 3'd3, dv(2, 1), 1'b0);
    #1 chk1("t5_stall", device_d_ready, 1'b0);
    tick(); #1;
    chk1("t5_stall2", device_d_ready, 1'b0);
    chk("t5_head0", 160'({host_d_valid, host_d}), 160'({1'b1, mk_hd(3'd1, 3'd3, {dv(0, 1), dv(0, 0)}, 1'b0)}));
    host_d_ready = 1;
    #1 chk1("t5_ready_indep", device_d_ready, 1'b0);
    tick(); host_d_ready = 0; #1;
    chk1("t5_resume", device_d_ready, 1'b1);
    chk("t5_head1", 160'({host_d_valid, host_d}), 160'({1'b1, mk_hd(3'd1, 3'd3, {dv(1, 1), dv(1, 0)}, 1'b0)}));
    tick(); device_d_valid = 0; #1;
    chk("t5_head1_hold", 160'({host_d_valid, host_d}), 160'({1'b1, mk_hd(3'd1, 3'd3, {dv(1, 1), dv(1, 0)}, 1'b0)}));
    host_d_ready = 1;
    tick(); #1;
    chk("t5_head2", 160'({host_d_valid, host_d}), 160'({1'b1, mk_hd(3'd1, 3'd3, {dv(2, 1), dv(2, 0)}, 1'b0)}));
    tick(); #1 chk1("t5_empty", host_d_valid, 1'b0);

    // Reset mid-burst with a queued D beat and a partial D assembly
    host_d_ready = 0;
    device_d = mk_dd(3'd0, 3'd2, 32'h0, 1'b0); device_d_valid = 1;
    tick();
    device_d = mk_dd(3'd5, 3'd6, 32'h5555_5555, 1'b1);
    tick(); device_d_valid = 0;
    #1 chk1("t6_queued", host_d_valid, 1'b1);
    host_a = mk_ha(3'd0, 3'd6, 56'h0, 8'hFF, 64'h8877665544332211); host_a_valid = 1; device_a_ready = 1;
    tick(); host_a_valid = 0;
    tick(); device_a_ready = 0; #1;
    chk("t6_mid", 160'({device_a_valid, device_a}), 160'({1'b1, mk_da(3'd0, 3'd6, 56'h0, 4'hF, 32'h88776655)}));
    rst_i = 1; #1;
    chk("t6_rst_a", 160'({device_a_valid, host_a_ready}), 160'(2'b01));
    chk("t6_rst_d", 160'({host_d_valid, device_d_ready}), 160'(2'b01));
    tick(); rst_i = 0; device_a_ready = 1;
    host_a = mk_ha(3'd0, 3'd3, 56'h100, 8'hFF, 64'hCAFEF00D12345678); host_a_valid = 1;
    tick(); host_a_valid = 0; #1;
    chk("t6_sb0", 160'({device_a_valid, device_a}), 160'({1'b1, mk_da(3'd0, 3'd3, 56'h100, 4'hF, 32'h12345678)}));
    tick(); #1;
    chk("t6_sb1", 160'({device_a_valid, device_a}), 160'({1'b1, mk_da(3'd0, 3'd3, 56'h100, 4'hF, 32'hCAFEF00D)}));
    host_d_ready = 1;
    device_d = mk_dd(3'd1, 3'd3, 32'h1111_1111, 1'b0); device_d_valid = 1;
    tick(); device_d = mk_dd(3'd1, 3'd3, 32'h2222_2222, 1'b0);
    #1 chk1("t6_d_partial", host_d_valid, 1'b0);
    tick(); device_d_valid = 0; #1;
    chk("t6_d_beat", 160'({host_d_valid, host_d}), 160'({1'b1, mk_hd(3'd1, 3'd3, 64'h2222222211111111, 1'b0)}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
